// File: rtl/array_access_arbiter_pkg.sv
// Shared types and constants for the array access arbiter.
package array_access_arbiter_pkg;

    // Top-level controller states: sweep after reset, normal service, sweep on request
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        SERVE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Per-requester accepted-transfer counter width and its saturation value
    localparam int GRANT_CNT_W = 16;
    localparam logic [GRANT_CNT_W-1:0] GRANT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/array_access_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// the pointer, wrapping modulo NUM_REQ.
module array_access_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               gnt_any_o
);

    // Distance from the pointer of the best candidate found so far
    int best;

    // Pick the requesting index with the smallest wrap-around distance from the pointer
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        best      = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_i[i] && (((i + NUM_REQ - int'(ptr_i)) % NUM_REQ) < best)) begin
                best        = (i + NUM_REQ - int'(ptr_i)) % NUM_REQ;
                gnt_oh_o    = '0;
                gnt_oh_o[i] = 1'b1;
                gnt_idx_o   = ID_W'(i);
                gnt_any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/array_access_arbiter.sv
// Shared ROWS x COLS register array with round-robin access for NUM_REQ
// requesters, one read or write per cycle, and a zero-fill sweeper that runs
// after reset and on i_clear.
// Optional per-requester grant statistics: define ARRAY_ACCESS_ARBITER_STATS_EN.
module array_access_arbiter
    import array_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ROWS    = 2,
    parameter int COLS    = 2,
    parameter int WIDTH   = 10,
    localparam int ROW_W  = $clog2(ROWS),
    localparam int COL_W  = $clog2(COLS),
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [NUM_REQ-1:0]                     i_req_valid,
    output logic [NUM_REQ-1:0]                     o_req_ready,
    input  logic [NUM_REQ-1:0]                     i_req_write,
    input  logic [NUM_REQ-1:0][ROW_W-1:0]          i_req_row,
    input  logic [NUM_REQ-1:0][COL_W-1:0]          i_req_col,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]          i_req_wdata,
    output logic [NUM_REQ-1:0]                     o_rsp_valid,
    output logic [WIDTH-1:0]                       o_rsp_rdata,
    input  logic                                   i_clear,
    output logic                                   o_busy,
    output logic [NUM_REQ-1:0][GRANT_CNT_W-1:0]    o_grant_count
);

    localparam int DEPTH = ROWS * COLS;
    localparam int IDX_W = ROW_W + COL_W;
    localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(DEPTH - 1);

    state_t             state_q;
    logic [IDX_W-1:0]   sweep_q;
    logic               busy_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               serve_clear;

    logic               gnt_write;
    logic [IDX_W-1:0]   gnt_addr;
    logic [WIDTH-1:0]   gnt_wdata;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [WIDTH-1:0]   rsp_rdata_q;

    // A clear seen in SERVE wins over any same-cycle request
    assign serve_clear = (state_q == SERVE) && i_clear;
    assign arb_req     = ((state_q == SERVE) && !i_clear) ? i_req_valid : '0;

    array_access_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i     (arb_req),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    assign o_req_ready = gnt_oh;

    // Row-major flat index: row*COLS + col is the concatenation for power-of-two sizes
    assign gnt_write = i_req_write[gnt_idx];
    assign gnt_addr  = {i_req_row[gnt_idx], i_req_col[gnt_idx]};
    assign gnt_wdata = i_req_wdata[gnt_idx];

    // Pointer advances past the winner on a transfer, holds otherwise
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    // Controller FSM: sweep counter, busy flag and round-robin pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= INIT;
            sweep_q <= '0;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            unique case (state_q)
                INIT, CLEAR: begin
                    if (sweep_q == SWEEP_LAST) begin
                        state_q <= SERVE;
                        sweep_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        sweep_q <= sweep_q + IDX_W'(1);
                    end
                end
                SERVE: begin
                    if (serve_clear) begin
                        state_q <= CLEAR;
                        sweep_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= INIT;
                    sweep_q <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign o_busy = busy_q;

    // Array storage: the sweep zero-fills one entry per cycle, otherwise a granted write lands
    always_ff @(posedge i_clk) begin
        if (state_q != SERVE) begin
            mem_q[sweep_q] <= '0;
        end else if (gnt_any && gnt_write) begin
            mem_q[gnt_addr] <= gnt_wdata;
        end
    end

    // Read response one cycle after the grant; read data holds between responses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= (gnt_any && !gnt_write) ? gnt_oh : '0;
            if (gnt_any && !gnt_write) begin
                rsp_rdata_q <= mem_q[gnt_addr];
            end
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;

`ifdef ARRAY_ACCESS_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][GRANT_CNT_W-1:0] cnt_q;

    function automatic logic [GRANT_CNT_W-1:0] sat_inc(input logic [GRANT_CNT_W-1:0] v);
        return (v == GRANT_CNT_MAX) ? v : v + GRANT_CNT_W'(1);
    endfunction

    // Accepted-transfer counters, zeroed on entry into a clear sweep
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (serve_clear) begin
            cnt_q <= '0;
        end else if (gnt_any) begin
            cnt_q[gnt_idx] <= sat_inc(cnt_q[gnt_idx]);
        end
    end

    assign o_grant_count = cnt_q;
`else
    assign o_grant_count = '0;
`endif

endmodule

// File: tb/tb_array_access_arbiter.sv
// Directed bench for array_access_arbiter with a behavioural model and a
// response scoreboard. Grant-count expectations follow ARRAY_ACCESS_ARBITER_STATS_EN.
module tb_array_access_arbiter;

    localparam int NR = 4;
    localparam int W  = 10;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NR-1:0]        valid, ready, write, rsp_valid;
    logic [NR-1:0][0:0]   row, col;
    logic [NR-1:0][W-1:0] wdata;
    logic [W-1:0]         rdata;
    logic                 clear, busy;
    logic [NR-1:0][15:0]  gcnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t         q[$];
    logic [W-1:0] m_mem [4];
    logic [15:0]  m_cnt [4];
    logic [W-1:0] m_rdata;
    int           m_ptr;
    int           m_sweep;
    int           rsp_seen [4];

    array_access_arbiter dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (valid),
        .o_req_ready   (ready),
        .i_req_write   (write),
        .i_req_row     (row),
        .i_req_col     (col),
        .i_req_wdata   (wdata),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_rdata   (rdata),
        .i_clear       (clear),
        .o_busy        (busy),
        .o_grant_count (gcnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_cnt();
        logic [63:0] r;
        r = '0;
`ifdef ARRAY_ACCESS_ARBITER_STATS_EN
        for (int i = 0; i < NR; i++) r[i*16 +: 16] = m_cnt[i];
`endif
        return r;
    endfunction

    task automatic set_req(input int i, input bit w, input int entry, input logic [W-1:0] d);
        valid[i] = 1'b1;
        write[i] = w;
        row[i]   = 1'(entry >> 1);
        col[i]   = 1'(entry & 1);
        wdata[i] = d;
    endtask

    // One clock cycle: check ready/busy/counters, advance the model, check the response
    task automatic step(input string tag);
        int          g;
        int          addr;
        logic [NR-1:0] er;
        rsp_t        e;
        #1;
        g = -1;
        if (m_sweep == 0 && !clear) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk({tag, " ready"}, 64'(ready), 64'(er));
        chk({tag, " busy"}, 64'(busy), 64'(m_sweep > 0));
        chk({tag, " grant_count"}, 64'(gcnt), exp_cnt());
        if (m_sweep > 0) begin
            m_sweep--;
        end else if (clear) begin
            m_sweep = 4;
            for (int i = 0; i < 4; i++) begin
                m_mem[i] = '0;
                m_cnt[i] = '0;
            end
        end else if (g >= 0) begin
            addr = int'(row[g]) * 2 + int'(col[g]);
            if (write[g]) m_mem[addr] = wdata[g];
            else q.push_back('{g, m_mem[addr]});
            m_ptr = (g + 1) % NR;
            if (m_cnt[g] != 16'hFFFF) m_cnt[g] = m_cnt[g] + 16'd1;
        end
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            m_rdata = e.data;
            rsp_seen[e.id]++;
            chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1 << e.id));
        end else begin
            chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(0));
        end
        chk({tag, " rsp_rdata"}, 64'(rdata), 64'(m_rdata));
    endtask

    initial begin
        rst_n = 1'b0;
        valid = '1;
        write = '0;
        row   = '0;
        col   = '0;
        wdata = '0;
        clear = 1'b0;
        m_ptr = 0;
        m_sweep = 4;
        m_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            m_mem[i] = '0;
            m_cnt[i] = '0;
            rsp_seen[i] = 0;
        end

        // Reset values while held in reset with requests pending
        #12;
        chk("reset busy", 64'(busy), 64'(1));
        chk("reset ready", 64'(ready), 64'(0));
        chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset rsp_rdata", 64'(rdata), 64'(0));
        chk("reset grant_count", 64'(gcnt), 64'(0));
        rst_n = 1'b1;

        // INIT sweep: four busy cycles with a request held off
        valid = '0;
        set_req(2, 1'b0, 0, '0);
        for (int i = 0; i < 4; i++) step("init");
        valid = '0;

        // Every entry reads back zero after INIT
        for (int e = 0; e < 4; e++) begin
            valid = '0;
            set_req(0, 1'b0, e, '0);
            step("init_readback");
        end

        // Write then read of the same entry in the next cycle
        valid = '0;
        set_req(0, 1'b1, 2, 10'h2A5);
        step("write");
        valid = '0;
        set_req(1, 1'b0, 2, '0);
        step("read_after_write");
        chk("read_after_write data", 64'(rdata), 64'(10'h2A5));

        // Write a second entry and bring the pointer back to 0
        valid = '0;
        set_req(2, 1'b1, 3, 10'h155);
        step("write2");
        valid = '0;
        set_req(3, 1'b0, 1, '0);
        step("ptr_to_0");

        // Fairness: all four hold reads for 8 cycles
        for (int i = 0; i < 4; i++) rsp_seen[i] = 0;
        valid = '0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, i, '0);
        for (int c = 0; c < 8; c++) step("fair");
        for (int i = 0; i < NR; i++) chk("fair rsp_count", 64'(rsp_seen[i]), 64'(2));

        // Pointer wrap and skip: move pointer to 3, then only req1 and req3 valid
        valid = '0;
        set_req(2, 1'b0, 3, '0);
        step("ptr_to_3");
        valid = '0;
        set_req(1, 1'b0, 2, '0);
        set_req(3, 1'b0, 3, '0);
        step("wrap_g3");
        step("wrap_g1");
        step("wrap_g3b");

        // Clear mid-traffic: a read granted the cycle before still completes
        valid = '0;
        set_req(1, 1'b0, 3, '0);
        step("pre_clear_read");
        valid = '0;
        set_req(2, 1'b0, 0, '0);
        clear = 1'b1;
        step("clear");
        clear = 1'b0;
        valid = '0;
        step("clear_busy");
        clear = 1'b1;
        step("clear_busy_ignored");
        clear = 1'b0;
        step("clear_busy");
        step("clear_busy");

        // Everything reads back zero after the clear
        for (int e = 0; e < 4; e++) begin
            valid = '0;
            set_req(3, 1'b0, e, '0);
            step("clear_readback");
        end

        // Five accepted transfers on req0
        for (int n = 0; n < 5; n++) begin
            valid = '0;
            set_req(0, 1'b1, n % 4, W'(n + 1));
            step("stats");
        end
        valid = '0;
        step("idle");
        chk("final grant_count", 64'(gcnt), exp_cnt());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
